// File: rtl/final_pio_pkg.sv
// Shared definitions for the PIO-style Avalon-MM slaves: register addresses
// and the per-bit debounce state encoding.
package final_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/final_key_debounce.sv
// One key bit: two-flop synchronizer, debounce counter/FSM, debounced level
// and a rise indication that is high in the cycle before debounced goes 0->1.
module final_key_debounce
  import final_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic debounced,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IMMEDIATE = (DEBOUNCE_CYCLES == 1) ? 1'b1 : 1'b0;

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;
  deb_state_e       state_r;

  // Synchronizer, counter and debounce state machine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      state_r <= STABLE;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      case (state_r)
        STABLE: begin
          if (sync2_r != deb_r) begin
            if (IMMEDIATE) begin
              deb_r <= sync2_r;
              cnt_r <= CNT_ZERO;
            end else begin
              state_r <= COUNT;
              cnt_r   <= CNT_ONE;
            end
          end else begin
            cnt_r <= CNT_ZERO;
          end
        end
        COUNT: begin
          if (sync2_r == deb_r) begin
            state_r <= STABLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            deb_r   <= sync2_r;
            cnt_r   <= CNT_ZERO;
            state_r <= STABLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= STABLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // Rise fires when the FSM is about to accept a new high level, so the
  // top can set EDGE on the same edge that debounced changes.
  always_comb begin
    rise = 1'b0;
    if (sync2_r && !deb_r) begin
      if (state_r == STABLE) begin
        rise = IMMEDIATE;
      end else if (cnt_r == CNT_LAST) begin
        rise = 1'b1;
      end else begin
        rise = 1'b0;
      end
    end else begin
      rise = 1'b0;
    end
  end

  assign debounced = deb_r;

endmodule

// File: rtl/final_button_ctrl.sv
// Avalon-MM push-button controller: debounced key levels, rising-edge
// capture with write-1-to-clear, interrupt mask and level irq.
module final_button_ctrl
  import final_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] mask_nxt_s;
  logic [WIDTH-1:0] edge_nxt_s;
  logic             wr_s;
  logic [31:0]      rd_mux_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    final_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .key      (in_port[i]),
      .debounced(deb_s[i]),
      .rise     (rise_s[i])
    );
  end

  // Next MASK/EDGE values; a rise sets EDGE even when the same bit is cleared.
  always_comb begin
    wr_s       = chipselect & ~write_n;
    mask_nxt_s = mask_r;
    edge_nxt_s = edge_r | rise_s;
    if (wr_s && (address == ADDR_MASK)) begin
      mask_nxt_s = writedata[WIDTH-1:0];
    end else begin
      mask_nxt_s = mask_r;
    end
    if (wr_s && (address == ADDR_EDGE)) begin
      edge_nxt_s = (edge_r & ~writedata[WIDTH-1:0]) | rise_s;
    end else begin
      edge_nxt_s = edge_r | rise_s;
    end
  end

  // Read mux; unused upper bits and the reserved address read as zero.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (address)
      ADDR_DATA: rd_mux_s[WIDTH-1:0] = deb_s;
      ADDR_MASK: rd_mux_s[WIDTH-1:0] = mask_r;
      ADDR_EDGE: rd_mux_s[WIDTH-1:0] = edge_r;
      default:   rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Register state; irq is built from next-state values so it tracks EDGE/MASK with no lag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r   <= {WIDTH{1'b0}};
      edge_r   <= {WIDTH{1'b0}};
      readdata <= 32'h0000_0000;
      irq      <= 1'b0;
    end else begin
      mask_r   <= mask_nxt_s;
      edge_r   <= edge_nxt_s;
      readdata <= rd_mux_s;
      irq      <= |(edge_nxt_s & mask_nxt_s);
    end
  end

endmodule

// File: tb/tb_final_button_ctrl.sv
// Scoreboard bench for final_button_ctrl with DEBOUNCE_CYCLES=4, WIDTH=4.
module tb_final_button_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'h0;
  logic        irq;

  final_button_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // bit 32 of an entry selects irq (1) or readdata (0) as the checked output
  logic [32:0] exp_q[$];
  string       nm_q[$];
  bit          req = 1'b0;
  bit          chk_pend = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [32:0] e_v;
  logic [31:0] act_v;
  string       nm_v;

  always @(posedge clk) chk_pend <= req;

  always @(negedge clk) begin
    if (chk_pend) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output present with no expected entry");
      end else begin
        e_v  = exp_q.pop_front();
        nm_v = nm_q.pop_front();
        act_v = e_v[32] ? {31'd0, irq} : readdata;
        if (act_v !== e_v[31:0]) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm_v, act_v, e_v[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // readdata after the next edge must equal e
  task automatic chk_rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    address = a;
    exp_q.push_back({1'b0, e});
    nm_q.push_back(nm);
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  // irq after the next edge must equal e
  task automatic chk_irq(input logic e, input string nm);
    exp_q.push_back({1'b1, 31'd0, e});
    nm_q.push_back(nm);
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    ticks(3);
    chk_rd(2'd0, 32'h0, "reset_readdata");
    chk_irq(1'b0, "reset_irq");
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) chk_rd(a[1:0], 32'h0, "post_reset_read");

    // clean press of bit 0 with MASK=1
    wr(2'd1, 32'h1);
    chk_rd(2'd1, 32'h1, "mask_readback");
    in_port = 4'b0001;
    ticks(4);
    chk_irq(1'b0, "press_irq_before_accept");
    chk_irq(1'b1, "press_irq_at_accept");
    chk_rd(2'd0, 32'h1, "press_data");
    chk_rd(2'd3, 32'h1, "press_edge");

    // bounce on bit 1: three cycles high is rejected, held high is accepted
    in_port = 4'b0011;
    ticks(3);
    in_port = 4'b0001;
    ticks(6);
    chk_rd(2'd0, 32'h1, "bounce_data");
    chk_rd(2'd3, 32'h1, "bounce_edge");
    in_port = 4'b0011;
    ticks(6);
    chk_rd(2'd0, 32'h3, "held_data");
    chk_rd(2'd3, 32'h3, "held_edge");

    // write-1-to-clear
    in_port = 4'b0111;
    ticks(7);
    chk_rd(2'd3, 32'h7, "w1c_edge_all");
    wr(2'd3, 32'h2);
    chk_rd(2'd3, 32'h5, "w1c_edge_5");
    wr(2'd3, 32'h4);
    chk_rd(2'd3, 32'h1, "w1c_edge_1");
    chk_irq(1'b1, "w1c_irq_before_clear");
    wr(2'd3, 32'h1);
    chk_irq(1'b0, "w1c_irq_after_clear");
    chk_rd(2'd3, 32'h0, "w1c_edge_0");

    // collision: clear of bit 1 on the edge where bit 1 sets
    in_port = 4'b0000;
    ticks(8);
    chk_rd(2'd0, 32'h0, "release_data");
    in_port = 4'b0010;
    ticks(5);
    wr(2'd3, 32'h2);
    chk_rd(2'd3, 32'h2, "collision_set_wins");

    // mask gating, reserved address, upper bits ignored
    wr(2'd3, 32'hF);
    wr(2'd1, 32'h0);
    in_port = 4'b1010;
    ticks(7);
    chk_rd(2'd3, 32'h8, "gate_edge");
    chk_irq(1'b0, "gate_irq_masked");
    wr(2'd1, 32'h8);
    chk_irq(1'b1, "gate_irq_unmasked");
    chk_rd(2'd1, 32'h8, "gate_mask");
    wr(2'd2, 32'hFFFF_FFFF);
    chk_rd(2'd2, 32'h0, "reserved_read");
    wr(2'd1, 32'hFFFF_FFF8);
    chk_rd(2'd1, 32'h8, "mask_upper_bits");
    chk_rd(2'd3, 32'h8, "edge_unchanged");

    // reset mid-count, key held through and after reset
    in_port = 4'b1110;
    ticks(3);
    reset_n = 1'b0;
    #1;
    chk_rd(2'd0, 32'h0, "midreset_data");
    chk_irq(1'b0, "midreset_irq");
    reset_n = 1'b1;
    ticks(5);
    chk_rd(2'd0, 32'h0, "reaccept_not_yet");
    chk_rd(2'd0, 32'hE, "reaccept_data");
    chk_rd(2'd3, 32'hE, "reaccept_edge");
    chk_irq(1'b0, "reaccept_irq_mask_reset");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
